// File: rtl/spi_slave_word.sv
// spi_slave_word: oversampled SPI slave, all CPOL/CPHA modes.
// Word-wide TX holding register and RX word output.
`timescale 1ns/1ps
module spi_slave_word #(
  parameter int unsigned       WORD_W    = 8,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter bit                LSB_FIRST = 1'b0,
  parameter int unsigned       SYNC_FF   = 2,
  parameter logic [WORD_W-1:0] TX_FILL   = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sclk_i,
  input  logic              spi_mosi_i,
  input  logic              spi_cs_n_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  input  logic [WORD_W-1:0] tx_data_i,
  input  logic              tx_vld_i,
  output logic              tx_rdy_o,
  output logic [WORD_W-1:0] rx_data_o,
  output logic              rx_vld_o,
  output logic              tx_urun_o,
  output logic              frame_start_o,
  output logic              frame_end_o
);

  localparam int CW = $clog2(WORD_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state;
  logic [SYNC_FF-1:0]  sclk_s;
  logic [SYNC_FF-1:0]  cs_s;
  logic [SYNC_FF-1:0]  mosi_s;
  logic                sclk_d;
  logic                cs_d;
  logic [CW-1:0]       cnt;
  logic                first_sh;
  logic [WORD_W-1:0]   sh_out;
  logic [WORD_W-1:0]   sh_in;
  logic [WORD_W-1:0]   hold;
  logic                hold_vld;

  logic                sclk_n;
  logic                mosi_n;
  logic                lead;
  logic                trail;
  logic                samp_e;
  logic                shft_e;
  logic                cs_fall;
  logic                cs_rise;
  logic                accept;
  logic                reload;
  logic                wrap;
  logic [WORD_W-1:0]   sh_in_nx;
  logic [WORD_W-1:0]   sh_out_nx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_s <= {SYNC_FF{CPOL}};
      cs_s   <= '1;
      mosi_s <= '0;
      sclk_d <= CPOL;
      cs_d   <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[SYNC_FF-2:0], spi_sclk_i};
      cs_s   <= {cs_s[SYNC_FF-2:0], spi_cs_n_i};
      mosi_s <= {mosi_s[SYNC_FF-2:0], spi_mosi_i};
      sclk_d <= sclk_s[SYNC_FF-1];
      cs_d   <= cs_s[SYNC_FF-1];
    end
  end

  assign sclk_n  = sclk_s[SYNC_FF-1];
  assign mosi_n  = mosi_s[SYNC_FF-1];
  assign lead    = (sclk_n != CPOL) && (sclk_d == CPOL);
  assign trail   = (sclk_n == CPOL) && (sclk_d != CPOL);
  assign samp_e  = CPHA ? trail : lead;
  assign shft_e  = CPHA ? lead : trail;
  assign cs_fall = !cs_s[SYNC_FF-1] && cs_d;
  assign cs_rise = cs_s[SYNC_FF-1] && !cs_d;
  assign accept  = tx_vld_i && !hold_vld;
  assign wrap    = (cnt == CW'(WORD_W - 1));

  // first shift of a CPHA=1 frame presents the entry-loaded word
  assign reload = (state == IDLE) ? cs_fall :
                  (shft_e && !cs_rise && cnt == '0 && !first_sh);

  always_comb begin
    sh_in_nx  = '0;
    sh_out_nx = '0;
    if (LSB_FIRST) begin
      sh_in_nx  = {mosi_n, sh_in[WORD_W-1:1]};
      sh_out_nx = {1'b0, sh_out[WORD_W-1:1]};
    end else begin
      sh_in_nx  = {sh_in[WORD_W-2:0], mosi_n};
      sh_out_nx = {sh_out[WORD_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      first_sh      <= 1'b0;
      sh_out        <= '0;
      sh_in         <= '0;
      hold          <= '0;
      hold_vld      <= 1'b0;
      rx_data_o     <= '0;
      rx_vld_o      <= 1'b0;
      tx_urun_o     <= 1'b0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
    end else begin
      rx_vld_o      <= 1'b0;
      tx_urun_o     <= 1'b0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      if (reload) begin
        if (hold_vld) begin
          sh_out   <= hold;
          hold_vld <= 1'b0;
        end else begin
          sh_out    <= TX_FILL;
          tx_urun_o <= 1'b1;
        end
      end
      if (accept) begin
        hold     <= tx_data_i;
        hold_vld <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state         <= ACTIVE;
            frame_start_o <= 1'b1;
            cnt           <= '0;
            first_sh      <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            frame_end_o <= 1'b1;
            cnt         <= '0;
          end else if (samp_e) begin
            sh_in <= sh_in_nx;
            if (wrap) begin
              cnt       <= '0;
              rx_data_o <= sh_in_nx;
              rx_vld_o  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (shft_e) begin
            first_sh <= 1'b0;
            if (cnt != '0) sh_out <= sh_out_nx;
          end
        end
      endcase
    end
  end

  assign tx_rdy_o      = !hold_vld;
  assign spi_miso_oe_o = (state == ACTIVE);
  assign spi_miso_o    = (state == ACTIVE) &&
                         (LSB_FIRST ? sh_out[0] : sh_out[WORD_W-1]);

endmodule

// File: tb/tb_spi_slave_word.sv
// tb_spi_slave_word: nine slave variants driven by a bit-level master.
// Expected words come from queue-based TX/RX models.
`timescale 1ns/1ps
module tb_spi_slave_word;

  localparam int N = 9;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        mosi = 1'b0;
  logic [15:0] txd  = '0;
  logic        sclk [N];
  logic        cs_n [N];
  logic        txv  [N];

  wire         miso_a [N];
  wire         oe_a   [N];
  wire         rdy_a  [N];
  wire         rxv_a  [N];
  wire         urun_a [N];
  wire         fs_a   [N];
  wire         fe_a   [N];
  wire  [15:0] rxd_a  [N];

  int tests = 0;
  int fails = 0;
  int sel   = 0;
  int n_rxv, n_urun, n_fs, n_fe;

  logic [15:0] mq[$];
  logic [15:0] last_sw[$];
  logic [15:0] txq[$];
  logic [15:0] rx_exp[$];

  always #5 clk = ~clk;

  // g: bit0 CPOL, bit1 CPHA, bit2 LSB_FIRST; g=8 is the 16-bit mode-0 variant
  for (genvar g = 0; g < N; g++) begin : gi
    localparam int W = (g == 8) ? 16 : 8;
    localparam bit PL = (g < 8) && (g % 2 == 1);
    localparam bit PH = (g < 8) && ((g / 2) % 2 == 1);
    localparam bit LF = (g < 8) && ((g / 4) % 2 == 1);
    localparam logic [W-1:0] FILL = (g == 8) ? '0 : '1;
    logic [W-1:0] rxd;
    spi_slave_word #(
      .WORD_W(W), .CPOL(PL), .CPHA(PH), .LSB_FIRST(LF),
      .SYNC_FF(2), .TX_FILL(FILL)
    ) u_dut (
      .clk_i(clk),
      .rst_i(rst),
      .spi_sclk_i(sclk[g]),
      .spi_mosi_i(mosi),
      .spi_cs_n_i(cs_n[g]),
      .spi_miso_o(miso_a[g]),
      .spi_miso_oe_o(oe_a[g]),
      .tx_data_i(txd[W-1:0]),
      .tx_vld_i(txv[g]),
      .tx_rdy_o(rdy_a[g]),
      .rx_data_o(rxd),
      .rx_vld_o(rxv_a[g]),
      .tx_urun_o(urun_a[g]),
      .frame_start_o(fs_a[g]),
      .frame_end_o(fe_a[g])
    );
    assign rxd_a[g] = 16'(rxd);
  end

  function automatic int wof(int s);
    return (s == 8) ? 16 : 8;
  endfunction
  function automatic bit cpol_of(int s);
    return (s < 8) && (s % 2 == 1);
  endfunction
  function automatic bit cpha_of(int s);
    return (s < 8) && ((s / 2) % 2 == 1);
  endfunction
  function automatic bit lsb_of(int s);
    return (s < 8) && ((s / 4) % 2 == 1);
  endfunction
  function automatic logic [15:0] msk_of(int s);
    return (s == 8) ? 16'hFFFF : 16'h00FF;
  endfunction
  function automatic logic [15:0] fill_of(int s);
    return (s == 8) ? 16'h0000 : 16'h00FF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (inst %0d): got %0h want %0h",
               nm, sel, act, exp);
    end
  endtask

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic push_tx(input int s, input logic [15:0] w);
    int t;
    t = 0;
    while (!rdy_a[s] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!rdy_a[s]) begin
      chk("tx_rdy_timeout", 32'(rdy_a[s]), 32'd1);
    end else begin
      txd    = w;
      txv[s] = 1'b1;
      @(negedge clk);
      txv[s] = 1'b0;
      txq.push_back(w & msk_of(s));
    end
  endtask

  // bit-level SPI master; collects MISO words into last_sw
  task automatic run_frame(input int nbits);
    int w;
    bit pl, ph, lf, b;
    logic [15:0] cur;
    w   = wof(sel);
    pl  = cpol_of(sel);
    ph  = cpha_of(sel);
    lf  = lsb_of(sel);
    cur = '0;
    last_sw = {};
    cs_n[sel] = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      int k, bp;
      k  = i / w;
      bp = lf ? (i % w) : (w - 1 - (i % w));
      if (!ph) begin
        mosi = mq[k][bp];
        half();
        b = miso_a[sel];
        sclk[sel] = ~pl;
        half();
        sclk[sel] = pl;
      end else begin
        sclk[sel] = ~pl;
        mosi = mq[k][bp];
        half();
        b = miso_a[sel];
        sclk[sel] = pl;
        half();
      end
      cur[bp] = b;
      if (i % w == w - 1) begin
        last_sw.push_back(cur);
        cur = '0;
      end
    end
    half();
    cs_n[sel] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // model: one TX load at frame entry, plus one per word boundary
  // shift edge (after each word for CPHA=0, before words 2.. for CPHA=1)
  task automatic do_frame(input int nbits);
    int w, nfull, loads, ue;
    logic [15:0] em[$];
    w     = wof(sel);
    nfull = nbits / w;
    ue    = 0;
    for (int k = 0; k < nfull; k++)
      rx_exp.push_back(mq[k] & msk_of(sel));
    n_rxv = 0; n_urun = 0; n_fs = 0; n_fe = 0;
    run_frame(nbits);
    loads = 1 + (cpha_of(sel) ? (nbits - 1) / w : nfull);
    for (int l = 0; l < loads; l++) begin
      if (txq.size() > 0) begin
        em.push_back(txq.pop_front());
      end else begin
        em.push_back(fill_of(sel));
        ue++;
      end
    end
    for (int k = 0; k < nfull; k++)
      chk("miso_word", 32'(last_sw[k]), 32'(em[k]));
    chk("rx_pulses", n_rxv, nfull);
    chk("rx_missing", rx_exp.size(), 0);
    rx_exp = {};
    chk("urun_pulses", n_urun, ue);
    chk("frame_start", n_fs, 1);
    chk("frame_end", n_fe, 1);
    chk("tx_rdy_after", 32'(rdy_a[sel]), 32'(txq.size() == 0));
  endtask

  int   quiet   = 0;
  logic cs_prev = 1'b1;

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst || cs_n[sel] !== cs_prev) quiet = 0;
    else if (quiet < 100) quiet++;
    cs_prev = cs_n[sel];
    if (quiet >= 6) begin
      chk("miso_oe", 32'(oe_a[sel]), 32'(!cs_n[sel]));
      if (cs_n[sel]) chk("miso_idle", 32'(miso_a[sel]), 32'd0);
    end
    if (rxv_a[sel]) begin
      n_rxv++;
      if (rx_exp.size() == 0) begin
        chk("rx_unexpected", 32'(rxv_a[sel]), 32'd0);
      end else begin
        e = rx_exp.pop_front();
        chk("rx_data", 32'(rxd_a[sel]), 32'(e));
      end
    end
    if (urun_a[sel]) n_urun++;
    if (fs_a[sel]) n_fs++;
    if (fe_a[sel]) n_fe++;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: run did not finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] tw[$];
    int s, nw, nb;
    for (int i = 0; i < N; i++) begin
      sclk[i] = cpol_of(i);
      cs_n[i] = 1'b1;
      txv[i]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      sel = i;
      chk("reset_tx_rdy", 32'(rdy_a[i]), 32'd1);
      chk("reset_oe", 32'(oe_a[i]), 32'd0);
      chk("reset_rx_vld", 32'(rxv_a[i]), 32'd0);
      chk("reset_rx_data", 32'(rxd_a[i]), 32'd0);
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // mode 0: preload A5, master sends 3C
    sel = 0;
    push_tx(0, 16'hA5);
    mq = {16'h3C};
    do_frame(8);
    chk("t1_miso_lit", 32'(last_sw[0]), 32'hA5);
    chk("t1_rx_lit", 32'(rxd_a[0]), 32'h3C);

    // all modes / bit orders, 81 <-> 5A loopback
    for (int m = 0; m < 8; m++) begin
      sel = m;
      push_tx(m, 16'h5A);
      mq = {16'h81};
      do_frame(8);
      chk("t2_miso_5a", 32'(last_sw[0]), 32'h5A);
      chk("t2_rx_81", 32'(rxd_a[m]), 32'h81);
      push_tx(m, 16'h81);
      mq = {16'h5A};
      do_frame(8);
      chk("t2_miso_81", 32'(last_sw[0]), 32'h81);
      chk("t2_rx_5a", 32'(rxd_a[m]), 32'h5A);
    end

    // 16-bit, three back-to-back words, holding reg refilled on tx_rdy
    sel = 8;
    tw = {16'hBEEF, 16'h1234, 16'hC0DE, 16'h0F0F};
    mq = {16'hCAFE, 16'h8001, 16'h7E57};
    push_tx(8, tw[0]);
    fork
      do_frame(48);
      for (int j = 1; j < 4; j++) push_tx(8, tw[j]);
    join
    chk("t3_rx_cnt", n_rxv, 3);
    chk("t3_no_urun", n_urun, 0);
    chk("t3_miso2_lit", 32'(last_sw[2]), 32'hC0DE);

    // no TX words: fill value and one underrun per word (CPHA=1)
    sel = 2;
    mq = {16'(($urandom)), 16'(($urandom)), 16'(($urandom))};
    do_frame(24);
    for (int k = 0; k < 3; k++)
      chk("t4_fill_lit", 32'(last_sw[k]), 32'hFF);
    chk("t4_urun_lit", n_urun, 3);

    // abort after 5 bits, then a clean frame
    sel = 0;
    mq = {16'h12};
    do_frame(5);
    chk("t5_no_rx", n_rxv, 0);
    do_frame(8);
    chk("t5_rx_lit", 32'(rxd_a[0]), 32'h12);

    // reset mid-word
    sel = 0;
    push_tx(0, 16'hC3);
    n_rxv = 0; n_fe = 0;
    cs_n[0] = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'($urandom);
      half();
      sclk[0] = 1'b1;
      half();
      if (i < 3) sclk[0] = 1'b0;
    end
    rst     = 1'b1;
    cs_n[0] = 1'b1;
    sclk[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_tx_rdy", 32'(rdy_a[0]), 32'd1);
    chk("t6_oe", 32'(oe_a[0]), 32'd0);
    chk("t6_miso", 32'(miso_a[0]), 32'd0);
    chk("t6_rx_vld", 32'(rxv_a[0]), 32'd0);
    chk("t6_rx_data", 32'(rxd_a[0]), 32'h12 & 32'h0);
    chk("t6_urun", 32'(urun_a[0]), 32'd0);
    txq = {};
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_no_frame_end", n_fe, 0);
    chk("t6_no_rx", n_rxv, 0);
    mq = {16'h77};
    do_frame(8);
    chk("t6_rx_lit", 32'(rxd_a[0]), 32'h77);
    chk("t6_miso_lit", 32'(last_sw[0]), 32'hFF);

    // randomized frames across all variants
    for (int r = 0; r < 30; r++) begin
      s   = $urandom_range(0, 8);
      sel = s;
      nw  = $urandom_range(1, 3);
      nb  = nw * wof(s);
      if ($urandom_range(0, 3) == 0) nb -= $urandom_range(1, wof(s) - 1);
      if ($urandom_range(0, 1) == 1) push_tx(s, 16'($urandom));
      mq = {};
      for (int k = 0; k < nw; k++) mq.push_back(16'($urandom));
      do_frame(nb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
